// File: rtl/assoc_cache.sv
`default_nettype none
// ============================================================================
// Module   : assoc_cache
// Purpose  : Set-associative write-back, write-allocate cache. One data word
//            per line, true-LRU replacement using per-way ages, and a simple
//            request/ack backing-memory port.
// Ports    : clock, reset (async, active-low)
//            read, write, address, data_in       - CPU request
//            data_out, hit, ready                - CPU response (ready pulses)
//            mem_req, mem_we, mem_addr, mem_wdata, mem_rdata, mem_ack
//                                                - backing-memory handshake
//            hit_count, miss_count               - saturating statistics
// Revision : 1.0 - initial release
// ============================================================================
module assoc_cache #(
    parameter int DATAWIDTH = 32,
    parameter int ADDRWIDTH = 32,
    parameter int INDEX     = 6,
    parameter int WAYS      = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 read,
    input  logic                 write,
    input  logic [ADDRWIDTH-1:0] address,
    input  logic [DATAWIDTH-1:0] data_in,
    output logic [DATAWIDTH-1:0] data_out,
    output logic                 hit,
    output logic                 ready,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [ADDRWIDTH-1:0] mem_addr,
    output logic [DATAWIDTH-1:0] mem_wdata,
    input  logic [DATAWIDTH-1:0] mem_rdata,
    input  logic                 mem_ack,
    output logic [31:0]          hit_count,
    output logic [31:0]          miss_count
);

    localparam int c_SETS = 1 << INDEX;
    localparam int c_TAGW = ADDRWIDTH - INDEX;
    localparam int c_AGEW = (WAYS > 1) ? $clog2(WAYS) : 1;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_WB   = 2'd1;
    localparam logic [1:0] c_FILL = 2'd2;
    localparam logic [1:0] c_RESP = 2'd3;

    logic [1:0]           r_state;
    logic                 r_valid [c_SETS][WAYS];
    logic                 r_dirty [c_SETS][WAYS];
    logic [c_TAGW-1:0]    r_tag   [c_SETS][WAYS];
    logic [DATAWIDTH-1:0] r_data  [c_SETS][WAYS];
    logic [c_AGEW-1:0]    r_age   [c_SETS][WAYS];

    // Request captured at acceptance
    logic [ADDRWIDTH-1:0] r_addr;
    logic [DATAWIDTH-1:0] r_wdata;
    logic                 r_is_wr;
    logic [c_AGEW-1:0]    r_way;

    logic [DATAWIDTH-1:0] r_data_out;
    logic                 r_hit;
    logic                 r_ready;
    logic [ADDRWIDTH-1:0] r_mem_addr;
    logic [DATAWIDTH-1:0] r_mem_wdata;
    logic [31:0]          r_hit_count;
    logic [31:0]          r_miss_count;

    logic                 w_accept;
    logic                 w_is_wr;
    logic [INDEX-1:0]     w_idx;
    logic [c_TAGW-1:0]    w_tag;
    logic                 w_hit;
    logic [c_AGEW-1:0]    w_hit_way;
    logic [c_AGEW-1:0]    w_victim;
    logic                 w_found;
    logic                 w_victim_dirty;

    // Line update bus: w_touch marks a completed access (LRU update),
    // w_inst additionally rewrites the line contents.
    logic                 w_touch;
    logic                 w_inst;
    logic [INDEX-1:0]     w_set;
    logic [c_AGEW-1:0]    w_way;
    logic [c_TAGW-1:0]    w_new_tag;
    logic [DATAWIDTH-1:0] w_new_data;
    logic                 w_new_dirty;

    assign w_accept = (r_state == c_IDLE) && (read || write);
    assign w_is_wr  = write && !read;           // read wins when both asserted
    assign w_idx    = address[INDEX-1:0];
    assign w_tag    = address[ADDRWIDTH-1:INDEX];

    // Tag lookup and victim choice for the incoming request
    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = '0;
        w_victim  = '0;
        w_found   = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag)) begin
                w_hit     = 1'b1;
                w_hit_way = c_AGEW'(w);
            end
        end
        for (int w = 0; w < WAYS; w++) begin
            if (!r_valid[w_idx][w] && !w_found) begin
                w_victim = c_AGEW'(w);
                w_found  = 1'b1;
            end
        end
        if (!w_found) begin
            for (int w = 0; w < WAYS; w++) begin
                if (r_age[w_idx][w] == c_AGEW'(WAYS - 1)) begin
                    w_victim = c_AGEW'(w);
                end
            end
        end
    end

    assign w_victim_dirty = r_valid[w_idx][w_victim] && r_dirty[w_idx][w_victim];

    always_comb begin
        w_touch     = 1'b0;
        w_inst      = 1'b0;
        w_set       = w_idx;
        w_way       = w_hit_way;
        w_new_tag   = w_tag;
        w_new_data  = data_in;
        w_new_dirty = 1'b1;
        case (r_state)
            c_IDLE: begin
                if (w_accept) begin
                    if (w_hit) begin
                        w_touch = 1'b1;
                        w_inst  = w_is_wr;
                    end else if (w_is_wr && !w_victim_dirty) begin
                        // write-allocate without fetch
                        w_touch = 1'b1;
                        w_inst  = 1'b1;
                        w_way   = w_victim;
                    end
                end
            end
            c_WB: begin
                if (mem_ack && r_is_wr) begin
                    w_touch    = 1'b1;
                    w_inst     = 1'b1;
                    w_set      = r_addr[INDEX-1:0];
                    w_way      = r_way;
                    w_new_tag  = r_addr[ADDRWIDTH-1:INDEX];
                    w_new_data = r_wdata;
                end
            end
            c_FILL: begin
                if (mem_ack) begin
                    w_touch     = 1'b1;
                    w_inst      = 1'b1;
                    w_set       = r_addr[INDEX-1:0];
                    w_way       = r_way;
                    w_new_tag   = r_addr[ADDRWIDTH-1:INDEX];
                    w_new_data  = mem_rdata;
                    w_new_dirty = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Tag/data storage needs no reset: valid bits gate every use
    always_ff @(posedge clock) begin
        if (w_inst) begin
            r_tag[w_set][w_way]  <= w_new_tag;
            r_data[w_set][w_way] <= w_new_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= c_IDLE;
            for (int s = 0; s < c_SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    r_valid[s][w] <= 1'b0;
                    r_dirty[s][w] <= 1'b0;
                    r_age[s][w]   <= c_AGEW'(w);
                end
            end
            r_addr       <= '0;
            r_wdata      <= '0;
            r_is_wr      <= 1'b0;
            r_way        <= '0;
            r_data_out   <= '0;
            r_hit        <= 1'b0;
            r_ready      <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            r_ready <= 1'b0;

            if (w_inst) begin
                r_valid[w_set][w_way] <= 1'b1;
                r_dirty[w_set][w_way] <= w_new_dirty;
            end

            // Accessed way becomes youngest; only younger ways age by one
            if (w_touch) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (c_AGEW'(w) == w_way) begin
                        r_age[w_set][w] <= '0;
                    end else if (r_age[w_set][w] < r_age[w_set][w_way]) begin
                        r_age[w_set][w] <= r_age[w_set][w] + c_AGEW'(1);
                    end
                end
            end

            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_addr  <= address;
                        r_wdata <= data_in;
                        r_is_wr <= w_is_wr;
                        if (w_hit) begin
                            r_ready    <= 1'b1;
                            r_hit      <= 1'b1;
                            r_data_out <= w_is_wr ? data_in : r_data[w_idx][w_hit_way];
                            if (r_hit_count != 32'hFFFF_FFFF) begin
                                r_hit_count <= r_hit_count + 32'd1;
                            end
                        end else begin
                            r_way <= w_victim;
                            if (w_victim_dirty) begin
                                r_state     <= c_WB;
                                r_mem_addr  <= {r_tag[w_idx][w_victim], w_idx};
                                r_mem_wdata <= r_data[w_idx][w_victim];
                            end else if (w_is_wr) begin
                                r_state    <= c_RESP;
                                r_ready    <= 1'b1;
                                r_hit      <= 1'b0;
                                r_data_out <= data_in;
                                if (r_miss_count != 32'hFFFF_FFFF) begin
                                    r_miss_count <= r_miss_count + 32'd1;
                                end
                            end else begin
                                r_state    <= c_FILL;
                                r_mem_addr <= address;
                            end
                        end
                    end
                end
                c_WB: begin
                    if (mem_ack) begin
                        if (r_is_wr) begin
                            r_state    <= c_RESP;
                            r_ready    <= 1'b1;
                            r_hit      <= 1'b0;
                            r_data_out <= r_wdata;
                            if (r_miss_count != 32'hFFFF_FFFF) begin
                                r_miss_count <= r_miss_count + 32'd1;
                            end
                        end else begin
                            r_state    <= c_FILL;
                            r_mem_addr <= r_addr;
                        end
                    end
                end
                c_FILL: begin
                    if (mem_ack) begin
                        r_state    <= c_RESP;
                        r_ready    <= 1'b1;
                        r_hit      <= 1'b0;
                        r_data_out <= mem_rdata;
                        if (r_miss_count != 32'hFFFF_FFFF) begin
                            r_miss_count <= r_miss_count + 32'd1;
                        end
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // Request strobes decode straight from state so reset drops them at once
    assign mem_req    = (r_state == c_WB) || (r_state == c_FILL);
    assign mem_we     = (r_state == c_WB);
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign data_out   = r_data_out;
    assign hit        = r_hit;
    assign ready      = r_ready;
    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;

endmodule
`default_nettype wire

// File: tb/tb_assoc_cache.sv
`default_nettype none
// ============================================================================
// Module   : tb_assoc_cache
// Purpose  : Directed, table-driven bench for assoc_cache. Two instances:
//            2-way and 4-way, both with 16 sets. A small memory responder
//            acks every memory request three cycles after it appears.
// Revision : 1.0 - initial release
// ============================================================================
module tb_assoc_cache;

    typedef struct {
        bit          four;
        bit          rst;
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] din;
        logic [31:0] rdata;
        bit          ehit;
        logic [31:0] edata;
        bit          ewb;
        logic [31:0] ewba;
        logic [31:0] ewbd;
        bit          efill;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        sel4  = 1'b0;
    logic        rq_rd = 1'b0;
    logic        rq_wr = 1'b0;
    logic        ack   = 1'b0;
    logic [31:0] address   = '0;
    logic [31:0] data_in   = '0;
    logic [31:0] mem_rdata = '0;

    logic        read2, write2, ack2, read4, write4, ack4;
    logic [31:0] data_out2, data_out4, mem_addr2, mem_addr4, mem_wdata2, mem_wdata4;
    logic [31:0] hit_count2, hit_count4, miss_count2, miss_count4;
    logic        hit2, hit4, ready2, ready4, mem_req2, mem_req4, mem_we2, mem_we4;

    assign read2  = rq_rd & ~sel4;
    assign write2 = rq_wr & ~sel4;
    assign ack2   = ack & ~sel4;
    assign read4  = rq_rd & sel4;
    assign write4 = rq_wr & sel4;
    assign ack4   = ack & sel4;

    // Selected-instance view
    logic        s_hit, s_ready, s_req, s_we;
    logic [31:0] s_dout, s_maddr, s_mwdata, s_hcnt, s_mcnt;
    assign s_hit    = sel4 ? hit4        : hit2;
    assign s_ready  = sel4 ? ready4      : ready2;
    assign s_req    = sel4 ? mem_req4    : mem_req2;
    assign s_we     = sel4 ? mem_we4     : mem_we2;
    assign s_dout   = sel4 ? data_out4   : data_out2;
    assign s_maddr  = sel4 ? mem_addr4   : mem_addr2;
    assign s_mwdata = sel4 ? mem_wdata4  : mem_wdata2;
    assign s_hcnt   = sel4 ? hit_count4  : hit_count2;
    assign s_mcnt   = sel4 ? miss_count4 : miss_count2;

    assoc_cache #(.DATAWIDTH(32), .ADDRWIDTH(32), .INDEX(4), .WAYS(2)) dut2 (
        .clock(clock), .reset(reset), .read(read2), .write(write2),
        .address(address), .data_in(data_in), .data_out(data_out2),
        .hit(hit2), .ready(ready2), .mem_req(mem_req2), .mem_we(mem_we2),
        .mem_addr(mem_addr2), .mem_wdata(mem_wdata2), .mem_rdata(mem_rdata),
        .mem_ack(ack2), .hit_count(hit_count2), .miss_count(miss_count2)
    );

    assoc_cache #(.DATAWIDTH(32), .ADDRWIDTH(32), .INDEX(4), .WAYS(4)) dut4 (
        .clock(clock), .reset(reset), .read(read4), .write(write4),
        .address(address), .data_in(data_in), .data_out(data_out4),
        .hit(hit4), .ready(ready4), .mem_req(mem_req4), .mem_we(mem_we4),
        .mem_addr(mem_addr4), .mem_wdata(mem_wdata4), .mem_rdata(mem_rdata),
        .mem_ack(ack4), .hit_count(hit_count4), .miss_count(miss_count4)
    );

    always #5 clock = ~clock;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] m_hits   [2];
    logic [31:0] m_misses [2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(bit four, bit rst, bit rd, bit wr, logic [31:0] addr,
                                logic [31:0] din, logic [31:0] rdata, bit ehit,
                                logic [31:0] edata, bit ewb, logic [31:0] ewba,
                                logic [31:0] ewbd, bit efill);
        vec_t v;
        v = '{four, rst, rd, wr, addr, din, rdata, ehit, edata, ewb, ewba, ewbd, efill};
        return v;
    endfunction

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("rst_ready",    {31'd0, s_ready}, 32'd0);
        chk("rst_hit",      {31'd0, s_hit},   32'd0);
        chk("rst_mem_req",  {31'd0, s_req},   32'd0);
        chk("rst_data_out", s_dout,  32'd0);
        chk("rst_mem_addr", s_maddr, 32'd0);
        chk("rst_hit_cnt",  s_hcnt,  32'd0);
        chk("rst_miss_cnt", s_mcnt,  32'd0);
        for (int i = 0; i < 2; i++) begin
            m_hits[i]   = '0;
            m_misses[i] = '0;
        end
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        logic        got_hit;
        logic [31:0] got_data, wba, wbd;
        bit          wb, fill, tmo;
        int          lat, cnt, k;
        got_hit = 1'b0; got_data = '0; wba = '0; wbd = '0;
        wb = 0; fill = 0; tmo = 1; lat = 1; cnt = 0;
        k  = v.four ? 1 : 0;
        sel4 = v.four;
        if (v.rst) do_reset();
        @(negedge clock);
        rq_rd = v.rd; rq_wr = v.wr; address = v.addr; data_in = v.din; mem_rdata = v.rdata;
        @(negedge clock);
        rq_rd = 1'b0; rq_wr = 1'b0;
        for (int c = 0; c < 60; c++) begin
            if (s_ready) begin
                got_hit = s_hit; got_data = s_dout; tmo = 0;
                break;
            end
            ack = 1'b0;
            if (s_req) begin
                if (s_we) begin wb = 1; wba = s_maddr; wbd = s_mwdata; end
                else fill = 1;
                cnt++;
                if (cnt >= 3) begin ack = 1'b1; cnt = 0; end
            end
            @(negedge clock);
            lat++;
        end
        ack = 1'b0;
        if (v.ehit) begin
            if (m_hits[k] != 32'hFFFF_FFFF) m_hits[k] = m_hits[k] + 1;
        end else begin
            if (m_misses[k] != 32'hFFFF_FFFF) m_misses[k] = m_misses[k] + 1;
        end
        chk({nm, "_timeout"}, {31'd0, tmo}, 32'd0);
        chk({nm, "_hit"},  {31'd0, got_hit}, {31'd0, v.ehit});
        chk({nm, "_data"}, got_data, v.edata);
        chk({nm, "_wb"},   {31'd0, wb},   {31'd0, v.ewb});
        chk({nm, "_fill"}, {31'd0, fill}, {31'd0, v.efill});
        if (v.ewb) begin
            chk({nm, "_wb_addr"}, wba, v.ewba);
            chk({nm, "_wb_data"}, wbd, v.ewbd);
        end
        if (v.ehit) chk({nm, "_latency"}, lat, 32'd1);
        @(negedge clock);
        chk({nm, "_ready_pulse"}, {31'd0, s_ready}, 32'd0);
        chk({nm, "_hit_cnt"},  s_hcnt, m_hits[k]);
        chk({nm, "_miss_cnt"}, s_mcnt, m_misses[k]);
    endtask

    vec_t vq[$];

    initial begin
        m_hits   = '{default: '0};
        m_misses = '{default: '0};
        //            4 r rd wr addr    din      rdata         eh edata         wb wba    wbd  fill
        vq.push_back(mk(0,1,1,0,32'h10,32'h0,   32'hAAAA0001,0,32'hAAAA0001,0,32'h0, 32'h0,1));
        vq.push_back(mk(0,0,1,0,32'h10,32'h0,   32'h0,       1,32'hAAAA0001,0,32'h0, 32'h0,0));
        vq.push_back(mk(0,0,1,1,32'h10,32'hDEAD,32'h0,       1,32'hAAAA0001,0,32'h0, 32'h0,0));
        vq.push_back(mk(0,0,1,0,32'h10,32'h0,   32'h0,       1,32'hAAAA0001,0,32'h0, 32'h0,0));
        vq.push_back(mk(0,0,1,0,32'h50,32'h0,   32'h55,      0,32'h55,      0,32'h0, 32'h0,1));
        // 0x10 is the LRU victim; still clean, so no write-back
        vq.push_back(mk(0,0,1,0,32'h60,32'h0,   32'h66,      0,32'h66,      0,32'h0, 32'h0,1));
        vq.push_back(mk(0,1,0,1,32'h20,32'h5,   32'h0,       0,32'h5,       0,32'h0, 32'h0,0));
        vq.push_back(mk(0,0,0,1,32'h30,32'h6,   32'h0,       0,32'h6,       0,32'h0, 32'h0,0));
        vq.push_back(mk(0,0,1,0,32'h20,32'h0,   32'h0,       1,32'h5,       0,32'h0, 32'h0,0));
        vq.push_back(mk(0,0,0,1,32'h40,32'h7,   32'h0,       0,32'h7,       1,32'h30,32'h6,0));
        vq.push_back(mk(0,0,1,0,32'h40,32'h0,   32'h0,       1,32'h7,       0,32'h0, 32'h0,0));
        vq.push_back(mk(0,0,1,0,32'h30,32'h0,   32'h12345678,0,32'h12345678,1,32'h20,32'h5,1));
        // 4-way: fill set 3, touch 0,1,2,3,0, then a fifth tag evicts tag 2 (0x23)
        vq.push_back(mk(1,1,1,0,32'h13,32'h0,32'h13,0,32'h13,0,32'h0,32'h0,1));
        vq.push_back(mk(1,0,1,0,32'h23,32'h0,32'h23,0,32'h23,0,32'h0,32'h0,1));
        vq.push_back(mk(1,0,1,0,32'h33,32'h0,32'h33,0,32'h33,0,32'h0,32'h0,1));
        vq.push_back(mk(1,0,1,0,32'h43,32'h0,32'h43,0,32'h43,0,32'h0,32'h0,1));
        vq.push_back(mk(1,0,1,0,32'h13,32'h0,32'h0, 1,32'h13,0,32'h0,32'h0,0));
        vq.push_back(mk(1,0,1,0,32'h23,32'h0,32'h0, 1,32'h23,0,32'h0,32'h0,0));
        vq.push_back(mk(1,0,1,0,32'h33,32'h0,32'h0, 1,32'h33,0,32'h0,32'h0,0));
        vq.push_back(mk(1,0,1,0,32'h43,32'h0,32'h0, 1,32'h43,0,32'h0,32'h0,0));
        vq.push_back(mk(1,0,1,0,32'h13,32'h0,32'h0, 1,32'h13,0,32'h0,32'h0,0));
        vq.push_back(mk(1,0,1,0,32'h53,32'h0,32'h53,0,32'h53,0,32'h0,32'h0,1));
        vq.push_back(mk(1,0,1,0,32'h13,32'h0,32'h0, 1,32'h13,0,32'h0,32'h0,0));
        vq.push_back(mk(1,0,1,0,32'h33,32'h0,32'h0, 1,32'h33,0,32'h0,32'h0,0));
        vq.push_back(mk(1,0,1,0,32'h43,32'h0,32'h0, 1,32'h43,0,32'h0,32'h0,0));
        vq.push_back(mk(1,0,1,0,32'h23,32'h0,32'h23,0,32'h23,0,32'h0,32'h0,1));

        repeat (2) @(negedge clock);
        reset = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            run_vec(vq[i], $sformatf("v%0d", i));
        end

        // Reset asserted in the middle of a fill
        sel4 = 1'b0;
        do_reset();
        @(negedge clock);
        rq_rd = 1'b1; address = 32'h70; mem_rdata = 32'h77;
        @(negedge clock);
        rq_rd = 1'b0;
        chk("midfill_req", {31'd0, mem_req2}, 32'd1);
        @(posedge clock);
        #2 reset = 1'b0;
        #1 chk("midfill_req_drop", {31'd0, mem_req2}, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        m_hits[0] = '0; m_misses[0] = '0;
        run_vec(mk(0,0,1,0,32'h70,32'h0,32'h77,0,32'h77,0,32'h0,32'h0,1), "refetch");

        // Stray ack while idle is ignored
        @(negedge clock);
        ack = 1'b1;
        @(negedge clock);
        ack = 1'b0;
        chk("idle_ack_ready",   {31'd0, ready2},   32'd0);
        chk("idle_ack_mem_req", {31'd0, mem_req2}, 32'd0);
        chk("idle_ack_hit_cnt",  hit_count2,  m_hits[0]);
        chk("idle_ack_miss_cnt", miss_count2, m_misses[0]);
        run_vec(mk(0,0,1,0,32'h70,32'h0,32'h0,1,32'h77,0,32'h0,32'h0,0), "after_ack");

        // Saturation of the hit counter
        @(negedge clock);
        force dut2.r_hit_count = 32'hFFFF_FFFF;
        @(negedge clock);
        release dut2.r_hit_count;
        m_hits[0] = 32'hFFFF_FFFF;
        run_vec(mk(0,0,1,0,32'h70,32'h0,32'h0,1,32'h77,0,32'h0,32'h0,0), "saturate");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
